// File: rtl/pipeline_sequencer_pkg.sv
// rtl/pipeline_sequencer_pkg.sv - shared types and constants for the pipeline sequencer
package pipeline_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_FLUSH,
      ST_RUN,
      ST_STEP_WAIT,
      ST_STEP_EXEC,
      ST_HALTED
   } state_t;

   typedef enum logic {
      MODE_RUN,
      MODE_STEP
   } mode_t;

   localparam logic [1:0] CMD_LOAD = 2'b00;
   localparam logic [1:0] CMD_RUN  = 2'b01;
   localparam logic [1:0] CMD_STEP = 2'b10;

   localparam logic [5:0] HALT_OP_DEFAULT = 6'b111111;

endpackage

// File: rtl/pipeline_sequencer_if.sv
// rtl/pipeline_sequencer_if.sv - host command/byte, imem write and pipeline control bundle
interface pipeline_sequencer_if #(
   parameter int NB_DATA = 32,
   parameter int NB_ADDR = 10,
   parameter int NB_BYTE = 8
);
   logic               cmd_valid;
   logic [1:0]         cmd_code;
   logic               cmd_ready;
   logic               abort;
   logic [NB_BYTE-1:0] rx_byte;
   logic               rx_valid;
   logic               halt_wb;
   logic               imem_wr_en;
   logic [NB_ADDR-1:0] imem_wr_addr;
   logic [NB_DATA-1:0] imem_wr_data;
   logic               pipe_enable;
   logic               pipe_flush;
   logic [31:0]        cycle_count;
   logic               busy;
   logic               done;

   modport master (
      output cmd_valid, cmd_code, abort, rx_byte, rx_valid, halt_wb,
      input  cmd_ready, imem_wr_en, imem_wr_addr, imem_wr_data,
      input  pipe_enable, pipe_flush, cycle_count, busy, done
   );

   modport slave (
      input  cmd_valid, cmd_code, abort, rx_byte, rx_valid, halt_wb,
      output cmd_ready, imem_wr_en, imem_wr_addr, imem_wr_data,
      output pipe_enable, pipe_flush, cycle_count, busy, done
   );
endinterface

// File: rtl/pipeline_sequencer_word_assembler.sv
// rtl/pipeline_sequencer_word_assembler.sv - MSB-first byte-to-word packer
module word_assembler #(
   parameter int NB_DATA = 32,
   parameter int NB_BYTE = 8
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               clear,
   input  logic               byte_valid,
   input  logic [NB_BYTE-1:0] byte_in,
   output logic               word_valid,
   output logic [NB_DATA-1:0] word
);
   localparam int N_BYTES = NB_DATA / NB_BYTE;
   localparam int NB_CNT  = $clog2(N_BYTES);

   logic [NB_CNT-1:0]          byte_cnt;
   logic [NB_DATA-NB_BYTE-1:0] shift;

   // The final byte completes the word combinationally so the write can register on the same edge.
   assign word_valid = byte_valid && (byte_cnt == NB_CNT'(N_BYTES - 1));
   assign word       = {shift, byte_in};

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         byte_cnt <= '0;
         shift    <= '0;
      end else if (clear) begin
         byte_cnt <= '0;
      end else if (byte_valid) begin
         shift    <= word[NB_DATA-NB_BYTE-1:0];
         byte_cnt <= word_valid ? '0 : byte_cnt + 1'b1;
      end
   end
endmodule

// File: rtl/pipeline_sequencer.sv
// rtl/pipeline_sequencer.sv - sequences program load, free-run and single-step of the pipeline
module pipeline_sequencer
   import pipeline_sequencer_pkg::*;
#(
   parameter int         NB_DATA = 32,
   parameter int         NB_OP   = 6,
   parameter int         NB_ADDR = 10,
   parameter int         NB_BYTE = 8,
   parameter logic [5:0] HALT_OP = HALT_OP_DEFAULT
) (
   input logic                 clock,
   input logic                 reset,
   pipeline_sequencer_if.slave bus
);
   state_t             state, next_state;
   mode_t              mode, next_mode;
   logic [NB_ADDR-1:0] addr;
   logic               load_start;
   logic               cmd_fire;
   logic               byte_valid;
   logic               asm_clear;
   logic               word_valid;
   logic [NB_DATA-1:0] word;
   logic               last_word;

   assign bus.cmd_ready = (state == ST_IDLE) || (state == ST_STEP_WAIT) || (state == ST_HALTED);
   assign bus.busy      = (state == ST_LOAD) || (state == ST_FLUSH) ||
                          (state == ST_RUN)  || (state == ST_STEP_EXEC);
   assign bus.done      = (state == ST_HALTED);

   assign cmd_fire   = bus.cmd_valid && bus.cmd_ready;
   assign byte_valid = bus.rx_valid && (state == ST_LOAD) && !bus.abort;
   // Leaving LOAD for any reason throws away a partially assembled word.
   assign asm_clear  = (state != ST_LOAD) || bus.abort;
   assign last_word  = word_valid &&
                       ((word[NB_DATA-1 -: NB_OP] == NB_OP'(HALT_OP)) || (addr == '1));

   word_assembler #(
      .NB_DATA (NB_DATA),
      .NB_BYTE (NB_BYTE)
   ) u_word_assembler (
      .clock      (clock),
      .reset      (reset),
      .clear      (asm_clear),
      .byte_valid (byte_valid),
      .byte_in    (bus.rx_byte),
      .word_valid (word_valid),
      .word       (word)
   );

   always_comb begin
      next_state = state;
      next_mode  = mode;
      load_start = 1'b0;
      if (bus.abort) begin
         next_state = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE, ST_HALTED: begin
               if (cmd_fire) begin
                  case (bus.cmd_code)
                     CMD_LOAD: begin
                        next_state = ST_LOAD;
                        load_start = 1'b1;
                     end
                     CMD_RUN: begin
                        next_state = ST_FLUSH;
                        next_mode  = MODE_RUN;
                     end
                     CMD_STEP: begin
                        next_state = ST_FLUSH;
                        next_mode  = MODE_STEP;
                     end
                     default: ;
                  endcase
               end
            end
            ST_LOAD: begin
               if (last_word) next_state = ST_IDLE;
            end
            ST_FLUSH: begin
               next_state = (mode == MODE_RUN) ? ST_RUN : ST_STEP_WAIT;
            end
            ST_RUN: begin
               if (bus.halt_wb && bus.pipe_enable) next_state = ST_HALTED;
            end
            ST_STEP_WAIT: begin
               if (cmd_fire) begin
                  case (bus.cmd_code)
                     CMD_LOAD: begin
                        next_state = ST_LOAD;
                        load_start = 1'b1;
                     end
                     CMD_RUN:  next_state = ST_RUN;
                     CMD_STEP: next_state = ST_STEP_EXEC;
                     default: ;
                  endcase
               end
            end
            ST_STEP_EXEC: begin
               next_state = (bus.halt_wb && bus.pipe_enable) ? ST_HALTED : ST_STEP_WAIT;
            end
            default: next_state = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state            <= ST_IDLE;
         mode             <= MODE_RUN;
         addr             <= '0;
         bus.imem_wr_en   <= 1'b0;
         bus.imem_wr_addr <= '0;
         bus.imem_wr_data <= '0;
         bus.pipe_enable  <= 1'b0;
         bus.pipe_flush   <= 1'b0;
         bus.cycle_count  <= '0;
      end else begin
         state          <= next_state;
         mode           <= next_mode;
         bus.imem_wr_en <= word_valid;
         if (word_valid) begin
            bus.imem_wr_addr <= addr;
            bus.imem_wr_data <= word;
         end
         // The address parks at the top slot instead of wrapping onto address 0.
         if (load_start)
            addr <= '0;
         else if (word_valid && (addr != '1))
            addr <= addr + 1'b1;
         bus.pipe_enable <= (next_state == ST_RUN) || (next_state == ST_STEP_EXEC);
         bus.pipe_flush  <= (next_state == ST_FLUSH);
         if (next_state == ST_FLUSH)
            bus.cycle_count <= '0;
         else if (bus.pipe_enable && (bus.cycle_count != '1))
            bus.cycle_count <= bus.cycle_count + 1'b1;
      end
   end
endmodule
